// File: rtl/multdiv_pkg.sv
// Shared FSM encodings and the default queue depth for the mult/div issue queue.
package multdiv_pkg;
  typedef enum logic [1:0] {
    MD_IDLE  = 2'd0,
    MD_START = 2'd1,
    MD_RUN   = 2'd2
  } md_state_e;

  localparam int MD_DEFAULT_DEPTH = 4;
endpackage

// File: rtl/multdiv_queue_mem.sv
// DEPTH x {a, b, ir} register array: synchronous write at tail, combinational read.
module multdiv_queue_mem
  import multdiv_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int IR_WIDTH = 32,
  parameter int DEPTH    = MD_DEFAULT_DEPTH,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int ENTRY_W = 2 * WIDTH + IR_WIDTH
) (
  input  logic               clock,
  input  logic               wr_en_i,
  input  logic [PTR_W-1:0]   wr_ptr_i,
  input  logic [ENTRY_W-1:0] wr_dat_i,
  input  logic [PTR_W-1:0]   rd_ptr_i,
  output logic [ENTRY_W-1:0] rd_dat_o
);
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en_i) mem_q[wr_ptr_i] <= wr_dat_i;
  end

  assign rd_dat_o = mem_q[rd_ptr_i];
endmodule

// File: rtl/multdiv_issue_queue.sv
// Operand queue feeding the iterative mult/div unit; one op in flight, ctrl_start two cycles after a push to an idle queue.
// MULTDIV_FLUSH_EN adds a flush input that empties the queue and idles the FSM.
module multdiv_issue_queue
  import multdiv_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int IR_WIDTH = 32,
  parameter int DEPTH    = MD_DEFAULT_DEPTH,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ctrl_multdiv,
  input  logic [WIDTH-1:0]    in_a,
  input  logic [WIDTH-1:0]    in_b,
  input  logic [IR_WIDTH-1:0] in_ir,
  input  logic                result_ready,
`ifdef MULTDIV_FLUSH_EN
  input  logic                flush,
`endif
  output logic                full,
  output logic [CNT_W-1:0]    count,
  output logic                ctrl_start,
  output logic                is_running,
  output logic [WIDTH-1:0]    out_a,
  output logic [WIDTH-1:0]    out_b,
  output logic [IR_WIDTH-1:0] out_ir
);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = 2 * WIDTH + IR_WIDTH;

  logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d, rd_ptr;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                push, pop, flush_w;
  logic [ENTRY_W-1:0]  rd_dat;
  md_state_e           state_q;
  logic                ctrl_start_q, is_running_q;
  logic [WIDTH-1:0]    out_a_q, out_b_q;
  logic [IR_WIDTH-1:0] out_ir_q;

`ifdef MULTDIV_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign full = (count_q == CNT_W'(DEPTH));

  // The head slot stays occupied by the in-flight op until result_ready retires it.
  always_comb begin
    pop     = (state_q == MD_RUN) && result_ready && !flush_w;
    push    = ctrl_multdiv && (!full || pop) && !flush_w;
    head_d  = pop  ? head_q + PTR_W'(1) : head_q;
    tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
    if (flush_w) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
    rd_ptr = (state_q == MD_RUN) ? head_q + PTR_W'(1) : head_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  multdiv_queue_mem #(
    .WIDTH   (WIDTH),
    .IR_WIDTH(IR_WIDTH),
    .DEPTH   (DEPTH)
  ) u_mem (
    .clock   (clock),
    .wr_en_i (push),
    .wr_ptr_i(tail_q),
    .wr_dat_i({in_a, in_b, in_ir}),
    .rd_ptr_i(rd_ptr),
    .rd_dat_o(rd_dat)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= MD_IDLE;
      ctrl_start_q <= 1'b0;
      is_running_q <= 1'b0;
      out_a_q      <= '0;
      out_b_q      <= '0;
      out_ir_q     <= '0;
    end else if (flush_w) begin
      state_q      <= MD_IDLE;
      ctrl_start_q <= 1'b0;
      is_running_q <= 1'b0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (count_q != '0) begin
            state_q                        <= MD_START;
            ctrl_start_q                   <= 1'b1;
            is_running_q                   <= 1'b1;
            {out_a_q, out_b_q, out_ir_q}   <= rd_dat;
          end
        end
        MD_START: begin
          state_q      <= MD_RUN;
          ctrl_start_q <= 1'b0;
        end
        MD_RUN: begin
          // A second queued entry already sits at head+1, so issue it without an idle gap.
          if (result_ready) begin
            if (count_q > CNT_W'(1)) begin
              state_q                      <= MD_START;
              ctrl_start_q                 <= 1'b1;
              {out_a_q, out_b_q, out_ir_q} <= rd_dat;
            end else begin
              state_q      <= MD_IDLE;
              is_running_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q      <= MD_IDLE;
          ctrl_start_q <= 1'b0;
          is_running_q <= 1'b0;
        end
      endcase
    end
  end

  assign count      = count_q;
  assign ctrl_start = ctrl_start_q;
  assign is_running = is_running_q;
  assign out_a      = out_a_q;
  assign out_b      = out_b_q;
  assign out_ir     = out_ir_q;
endmodule
